// File: rtl/pc_next_calc_pkg.sv
// Shared constants and types for the next-PC calculation slice.
package pc_next_calc_pkg;

    localparam int XLEN_DEFAULT      = 64;
    localparam int PC_INC_DEFAULT    = 4;
    localparam int IMM_SHIFT_DEFAULT = 1;

    typedef logic [XLEN_DEFAULT-1:0] addr_t;

endpackage

// File: rtl/pc_next_calc_xlen_adder.sv
// Unsigned XLEN-bit adder; the sum wraps modulo 2^W and the bit above the MSB is reported as carry.
module xlen_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] wide_sum;

    assign wide_sum = {1'b0, a} + {1'b0, b};
    assign sum      = wide_sum[W-1:0];
    assign carry    = wide_sum[W];

endmodule

// File: rtl/pc_next_calc.sv
// Registered next-PC candidates: pc + PC_INC, imm << IMM_SHIFT and pc + (imm << IMM_SHIFT), with carries.
module pc_next_calc
    import pc_next_calc_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int PC_INC    = PC_INC_DEFAULT,
    parameter int IMM_SHIFT = IMM_SHIFT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic [XLEN-1:0] imm_shifted,
    output logic [XLEN-1:0] branch_target,
    output logic            inc_carry,
    output logic            tgt_carry
);

    localparam logic [XLEN-1:0] PC_INC_V = XLEN'(PC_INC);

    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] inc_sum;
    logic [XLEN-1:0] tgt_sum;
    logic            inc_co;
    logic            tgt_co;

    logic            out_valid_d,     out_valid_q;
    logic [XLEN-1:0] pc_plus_inc_d,   pc_plus_inc_q;
    logic [XLEN-1:0] imm_shifted_d,   imm_shifted_q;
    logic [XLEN-1:0] branch_target_d, branch_target_q;
    logic            inc_carry_d,     inc_carry_q;
    logic            tgt_carry_d,     tgt_carry_q;

    // Bits pushed past the MSB are intentionally dropped.
    assign imm_sh = imm << IMM_SHIFT;

    xlen_adder #(.W(XLEN)) u_inc_adder (
        .a     (pc),
        .b     (PC_INC_V),
        .sum   (inc_sum),
        .carry (inc_co)
    );

    xlen_adder #(.W(XLEN)) u_tgt_adder (
        .a     (pc),
        .b     (imm_sh),
        .sum   (tgt_sum),
        .carry (tgt_co)
    );

    always_comb begin
        out_valid_d     = in_valid;
        pc_plus_inc_d   = pc_plus_inc_q;
        imm_shifted_d   = imm_shifted_q;
        branch_target_d = branch_target_q;
        inc_carry_d     = inc_carry_q;
        tgt_carry_d     = tgt_carry_q;
        if (in_valid) begin
            pc_plus_inc_d   = inc_sum;
            imm_shifted_d   = imm_sh;
            branch_target_d = tgt_sum;
            inc_carry_d     = inc_co;
            tgt_carry_d     = tgt_co;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            pc_plus_inc_q   <= '0;
            imm_shifted_q   <= '0;
            branch_target_q <= '0;
            inc_carry_q     <= 1'b0;
            tgt_carry_q     <= 1'b0;
        end else begin
            out_valid_q     <= out_valid_d;
            pc_plus_inc_q   <= pc_plus_inc_d;
            imm_shifted_q   <= imm_shifted_d;
            branch_target_q <= branch_target_d;
            inc_carry_q     <= inc_carry_d;
            tgt_carry_q     <= tgt_carry_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign pc_plus_inc   = pc_plus_inc_q;
    assign imm_shifted   = imm_shifted_q;
    assign branch_target = branch_target_q;
    assign inc_carry     = inc_carry_q;
    assign tgt_carry     = tgt_carry_q;

endmodule

// File: tb/tb_pc_next_calc.sv
// Directed and random checks of pc_next_calc against an arithmetic reference model.
module tb_pc_next_calc;

    localparam int XLEN      = 64;
    localparam int PC_INC    = 4;
    localparam int IMM_SHIFT = 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            out_valid;
    logic [XLEN-1:0] pc_plus_inc;
    logic [XLEN-1:0] imm_shifted;
    logic [XLEN-1:0] branch_target;
    logic            inc_carry;
    logic            tgt_carry;

    int n_checks = 0;
    int n_pass   = 0;

    logic            exp_valid;
    logic [XLEN-1:0] exp_inc;
    logic [XLEN-1:0] exp_shift;
    logic [XLEN-1:0] exp_tgt;
    logic            exp_inc_c;
    logic            exp_tgt_c;

    pc_next_calc #(
        .XLEN      (XLEN),
        .PC_INC    (PC_INC),
        .IMM_SHIFT (IMM_SHIFT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .pc            (pc),
        .imm           (imm),
        .out_valid     (out_valid),
        .pc_plus_inc   (pc_plus_inc),
        .imm_shifted   (imm_shifted),
        .branch_target (branch_target),
        .inc_carry     (inc_carry),
        .tgt_carry     (tgt_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".out_valid"},     XLEN'(out_valid), XLEN'(exp_valid));
        check({tag, ".pc_plus_inc"},   pc_plus_inc,      exp_inc);
        check({tag, ".imm_shifted"},   imm_shifted,      exp_shift);
        check({tag, ".branch_target"}, branch_target,    exp_tgt);
        check({tag, ".inc_carry"},     XLEN'(inc_carry), XLEN'(exp_inc_c));
        check({tag, ".tgt_carry"},     XLEN'(tgt_carry), XLEN'(exp_tgt_c));
    endtask

    task automatic modelReset();
        exp_valid = 1'b0;
        exp_inc   = '0;
        exp_shift = '0;
        exp_tgt   = '0;
        exp_inc_c = 1'b0;
        exp_tgt_c = 1'b0;
    endtask

    // Reference: wrap-around sums, carry detected by the sum coming out smaller than an operand.
    task automatic modelLoad(input logic [XLEN-1:0] p, input logic [XLEN-1:0] i);
        logic [XLEN-1:0] scale;
        scale     = XLEN'(2 ** IMM_SHIFT);
        exp_valid = 1'b1;
        exp_shift = i * scale;
        exp_inc   = p + XLEN'(PC_INC);
        exp_inc_c = (exp_inc < p);
        exp_tgt   = p + exp_shift;
        exp_tgt_c = (exp_tgt < p);
    endtask

    // Drive one cycle of inputs, let the edge happen, then update the model.
    task automatic applyStimulus(input logic v, input logic [XLEN-1:0] p, input logic [XLEN-1:0] i);
        in_valid = v;
        pc       = p;
        imm      = i;
        @(posedge clk);
        #1;
        if (v) modelLoad(p, i);
        else exp_valid = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        $display("[TB] starting pc_next_calc bench");
        rst_n    = 1'b0;
        in_valid = 1'b1;
        pc       = 64'h1000;
        imm      = 64'h1234;
        modelReset();
        #2;
        checkOutput("reset_before_edge");
        @(posedge clk);
        #1;
        checkOutput("reset_after_edge");
        rst_n = 1'b1;

        applyStimulus(1'b1, 64'h1000, 64'hACCA_9090_8881_0456);
        check("vec029.imm_shifted_const",   imm_shifted,   64'h5995_2121_1102_08AC);
        check("vec029.branch_target_const", branch_target, 64'h5995_2121_1102_18AC);
        check("vec029.pc_plus_inc_const",   pc_plus_inc,   64'h1004);
        checkOutput("vec029");

        applyStimulus(1'b1, 64'h0, 64'hFFFF_8097_0001_2323);
        check("vec030.imm_shifted_const", imm_shifted,   64'hFFFF_012E_0002_4646);
        check("vec030.target_eq_shift",   branch_target, 64'hFFFF_012E_0002_4646);
        checkOutput("vec030");

        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        check("vec031.inc_wrap",  pc_plus_inc,      64'h0);
        check("vec031.inc_carry", XLEN'(inc_carry), 64'h1);
        checkOutput("vec031");

        applyStimulus(1'b1, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
        check("vec032.tgt_wrap",  branch_target,    64'h0);
        check("vec032.tgt_carry", XLEN'(tgt_carry), 64'h1);
        checkOutput("vec032");

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, rand64(), rand64());
            checkOutput($sformatf("hold%0d", k));
        end

        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, rand64(), rand64());
            checkOutput($sformatf("b2b%0d", k));
        end

        // Mid-stream reset: the result loaded just before must vanish immediately.
        applyStimulus(1'b1, rand64(), rand64());
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 64'h2000, 64'h10);
        checkOutput("post_reset_first");

        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), rand64(), rand64());
            checkOutput($sformatf("mix%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_next_calc.md
PC_NEXT_CALC -- requirements
Module: pc_next_calc

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits.
REQ-002 SHALL have parameter PC_INC, default 4, sequential PC increment.
REQ-003 SHALL have parameter IMM_SHIFT, default 1, left-shift amount applied to the immediate.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  pc/imm inputs valid this cycle.
REQ-007 pc  input  XLEN  current program counter.
REQ-008 imm  input  XLEN  sign-extended immediate from imm-gen.
REQ-009 out_valid  output  1  registered outputs hold a fresh result.
REQ-010 pc_plus_inc  output  XLEN  registered pc + PC_INC (adder1 path).
REQ-011 imm_shifted  output  XLEN  registered imm << IMM_SHIFT (left_shift path).
REQ-012 branch_target  output  XLEN  registered pc + (imm << IMM_SHIFT) (adder2 path).
REQ-013 inc_carry, tgt_carry  output  1 each  carry-out of the respective adder, registered.

Function
REQ-014 Shift SHALL be a logical left shift by IMM_SHIFT, zero-filling LSBs; bits shifted past bit XLEN-1 are discarded.
REQ-015 Both additions SHALL be unsigned modulo 2^XLEN; carry out of bit XLEN-1 goes to the carry output only.
REQ-016 Combinational sum/shift SHALL be computed from the same-cycle pc and imm; no cross-cycle mixing.
REQ-017 On a rising edge with in_valid=1, all result registers SHALL load; out_valid SHALL be 1 the following cycle (latency 1).
REQ-018 On a rising edge with in_valid=0, result registers SHALL hold their previous values and out_valid SHALL go to 0.
REQ-019 No backpressure: a new result every cycle in_valid=1; throughput 1 per clock.
REQ-020 Wrap-around: pc=2^XLEN-PC_INC gives pc_plus_inc=0, inc_carry=1.
REQ-021 Outputs SHALL not depend combinationally on inputs; all are register outputs.

Reset
REQ-022 While rst_n=0, out_valid, pc_plus_inc, imm_shifted, branch_target, inc_carry and tgt_carry SHALL be 0, asynchronously, regardless of clk.
REQ-023 On rst_n deassertion, the first rising edge with in_valid=1 SHALL load normally; no extra warm-up cycle.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result; no partial values visible after reset.

Structure
REQ-025 Shared package SHALL hold XLEN default, PC_INC default and IMM_SHIFT default constants, plus an addr_t typedef of XLEN bits.
REQ-026 One sub-module, xlen_adder (XLEN-bit add with carry-out), SHALL be instantiated twice: sequential increment and branch target.
REQ-027 The shift SHALL be inline logic, not a separate module.

Verification
REQ-028 Reset: rst_n=0 with in_valid=1, pc=0x1000 -> all outputs 0, out_valid=0, before any clock edge.
REQ-029 imm=0xACCA_9090_8881_0456, pc=0x1000, in_valid=1 -> next cycle imm_shifted=0x5995_2121_1102_08AC, pc_plus_inc=0x1004, branch_target=0x5995_2121_1102_18AC, out_valid=1.
REQ-030 imm=0xFFFF_8097_0001_2323, pc=0 -> imm_shifted=0xFFFF_012E_0002_4646, branch_target equal to imm_shifted, tgt_carry=0.
REQ-031 pc=0xFFFF_FFFF_FFFF_FFFC, imm=0 -> pc_plus_inc=0, inc_carry=1, branch_target=pc, tgt_carry=0.
REQ-032 pc=0x8000_0000_0000_0000, imm=0x4000_0000_0000_0000 -> imm_shifted=0x8000_0000_0000_0000, branch_target=0, tgt_carry=1.
REQ-033 Load, then hold in_valid=0 for 3 cycles -> out_valid=0, data outputs unchanged; then back-to-back in_valid=1 -> one result per cycle in input order.
